// File: rtl/pwm_dac_mc.sv
// Multi-channel PWM DAC: one shared window counter, double-buffered samples applied at window boundaries.
// Optional sticky underrun flag enabled by defining PWM_DAC_UNDERRUN_EN.
module pwm_dac_mc #(
    parameter int NUM_CH     = 4,
    parameter int CODE_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*CODE_WIDTH-1:0] in_codes,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         next_sample,
    output logic [NUM_CH-1:0]            pwm,
    input  logic                         underrun_clr,
    output logic                         underrun
);
    localparam int BUS_W = NUM_CH * CODE_WIDTH;
    localparam logic [CODE_WIDTH-1:0] CNT_MAX = '1;

    logic [CODE_WIDTH-1:0] counter_q, counter_d;
    logic [BUS_W-1:0]      pending_q, pending_d;
    logic [BUS_W-1:0]      active_q, active_d;
    logic                  pending_full_q, pending_full_d;
    logic [NUM_CH-1:0]     pwm_q, pwm_d;
    logic                  boundary;
    logic                  accept;

    assign boundary    = (counter_q == CNT_MAX);
    assign in_ready    = !pending_full_q;
    assign accept      = in_valid && !pending_full_q;
    assign next_sample = boundary;
    assign pwm         = pwm_q;

    always_comb begin
        counter_d      = counter_q + 1'b1;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        pwm_d          = '0;
        // An accept coinciding with a boundary only fills pending; it is applied one window later.
        if (accept) begin
            pending_d      = in_codes;
            pending_full_d = 1'b1;
        end
        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (counter_q < active_q[i*CODE_WIDTH +: CODE_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            pwm_q          <= '0;
        end else begin
            counter_q      <= counter_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            pwm_q          <= pwm_d;
        end
    end

`ifdef PWM_DAC_UNDERRUN_EN
    logic underrun_q, underrun_d;

    // Setting takes priority over a clear on the same edge.
    always_comb begin
        underrun_d = underrun_q;
        if (boundary && !pending_full_q) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_underrun_clr;
    assign unused_underrun_clr = underrun_clr;
    assign underrun            = 1'b0;
`endif

endmodule
